stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl.sv | 140 ++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: button edge detect, prescaler, lap capture and overflow.
// Optional lap feature is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl #(
   parameter int PRESCALE = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_start,
   input  logic        btn_lap,
   input  logic        btn_clear,
   input  logic [19:0] time_in,
   output logic        cnt_enable,
   output logic        cnt_clear,
   output logic [1:0]  state,
   output logic [19:0] lap_time,
   output logic [19:0] disp_time,
   output logic        ovf
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10,
      LAP   = 2'b11
   } state_t;

   localparam int PW = $clog2(PRESCALE);
   localparam logic [PW-1:0] TOP = PW'(PRESCALE - 1);

   state_t        cur;
   state_t        nxt;
   logic [PW-1:0] presc;
   logic [PW-1:0] presc_n;
   logic [2:0]    btns;
   logic [2:0]    hist;
   logic [2:0]    arm;
   logic [2:0]    ev;
   logic          ovf_n;
   logic          clr_n;
   logic          counting;
   logic          tick;

   // arm stays low until a button is seen released after reset
   assign btns  = {btn_clear, btn_start, btn_lap};
   assign ev    = btns & ~hist & arm;
   assign state = cur;

`ifdef STOPWATCH_LAP_EN
   logic [19:0] lap_q;
   logic [19:0] lap_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         lap_q <= '0;
      end else begin
         lap_q <= lap_n;
      end
   end

   assign lap_time  = lap_q;
   assign disp_time = (cur == LAP) ? lap_q : time_in;
`else
   assign lap_time  = '0;
   assign disp_time = time_in;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         cur       <= IDLE;
         presc     <= '0;
         hist      <= '0;
         arm       <= '0;
         ovf       <= 1'b0;
         cnt_clear <= 1'b1;
      end else begin
         cur       <= nxt;
         presc     <= presc_n;
         hist      <= btns;
         arm       <= arm | ~btns;
         ovf       <= ovf_n;
         cnt_clear <= clr_n;
      end
   end

   always_comb begin
      nxt      = cur;
      presc_n  = presc;
      ovf_n    = ovf;
      clr_n    = 1'b0;
`ifdef STOPWATCH_LAP_EN
      lap_n    = lap_q;
`endif
      counting = (cur == RUN) || (cur == LAP);
      tick     = counting && (presc == TOP);
      // a clear in the same cycle suppresses the tick
      cnt_enable = tick && !ev[2] && !rst;

      if (counting) begin
         presc_n = tick ? '0 : presc + 1'b1;
      end
      if (cnt_enable && (time_in == 20'h59999)) begin
         ovf_n = 1'b1;
      end

      priority case (1'b1)
         ev[2]: begin
            nxt     = IDLE;
            clr_n   = 1'b1;
            presc_n = '0;
            ovf_n   = 1'b0;
`ifdef STOPWATCH_LAP_EN
            lap_n   = '0;
`endif
         end
         ev[1]: begin
            unique case (cur)
               IDLE: begin
                  nxt     = RUN;
                  presc_n = '0;
               end
               RUN,
               LAP:   nxt = PAUSE;
               PAUSE: nxt = RUN;
            endcase
         end
`ifdef STOPWATCH_LAP_EN
         ev[0]: begin
            if (cur == RUN) begin
               nxt   = LAP;
               lap_n = time_in;
            end else if (cur == LAP) begin
               nxt = RUN;
            end
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with PRESCALE=4.
// Each stimulus cycle queues the outputs expected at that cycle's falling edge.
module tb_stopwatch_ctrl;

   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_RUN   = 2'b01;
   localparam logic [1:0] S_PAUSE = 2'b10;
   localparam logic [1:0] S_LAP   = 2'b11;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        btn_start = 1'b0;
   logic        btn_lap = 1'b0;
   logic        btn_clear = 1'b0;
   logic [19:0] time_in = '0;
   logic        cnt_enable;
   logic        cnt_clear;
   logic [1:0]  state;
   logic [19:0] lap_time;
   logic [19:0] disp_time;
   logic        ovf;

   typedef struct {
      logic [1:0]  st;
      logic        en;
      logic        clr;
      logic        ovf;
      logic [19:0] lap;
      logic [19:0] disp;
      string       nm;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0;
   int   n_fail = 0;

   stopwatch_ctrl #(.PRESCALE(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .btn_start  (btn_start),
      .btn_lap    (btn_lap),
      .btn_clear  (btn_clear),
      .time_in    (time_in),
      .cnt_enable (cnt_enable),
      .cnt_clear  (cnt_clear),
      .state      (state),
      .lap_time   (lap_time),
      .disp_time  (disp_time),
      .ovf        (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input string f,
                      input logic [19:0] got, input logic [19:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s.%s got=%h exp=%h", nm, f, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk(e.nm, "state", {18'd0, state}, {18'd0, e.st});
         chk(e.nm, "cnt_enable", {19'd0, cnt_enable}, {19'd0, e.en});
         chk(e.nm, "cnt_clear", {19'd0, cnt_clear}, {19'd0, e.clr});
         chk(e.nm, "ovf", {19'd0, ovf}, {19'd0, e.ovf});
         chk(e.nm, "lap_time", lap_time, e.lap);
         chk(e.nm, "disp_time", disp_time, e.disp);
      end
   end

   task automatic cyc(input logic r, input logic s, input logic l,
                      input logic c, input logic [19:0] t,
                      input logic [1:0] est, input logic een,
                      input logic eclr, input logic eovf,
                      input logic [19:0] elap, input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      rst       = r;
      btn_start = s;
      btn_lap   = l;
      btn_clear = c;
      time_in   = t;
      e.st   = est;
      e.en   = een;
      e.clr  = eclr;
      e.ovf  = eovf;
      e.lap  = elap;
      e.disp = (est == S_LAP) ? elap : t;
      e.nm   = nm;
      q.push_back(e);
   endtask

   initial begin
      // reset with start held through release: no event until re-pressed
      cyc(1, 1, 0, 0, 0, S_IDLE, 0, 1, 0, 0, "rst");
      cyc(0, 1, 0, 0, 0, S_IDLE, 0, 1, 0, 0, "rst_edge");
      cyc(0, 1, 0, 0, 0, S_IDLE, 0, 0, 0, 0, "held1");
      cyc(0, 0, 0, 0, 0, S_IDLE, 0, 0, 0, 0, "held2");
      cyc(0, 0, 0, 0, 0, S_IDLE, 0, 0, 0, 0, "idle");

      // start: ticks on cycles 4, 8, 12 after the event edge
      cyc(0, 1, 0, 0, 0, S_IDLE, 0, 0, 0, 0, "start");
      for (int k = 1; k <= 12; k++)
         cyc(0, 0, 0, 0, 0, S_RUN, (k % 4) == 0, 0, 0, 0, "run12");

      // pause after two cycles, hold ten, resume
      cyc(0, 0, 0, 0, 0, S_RUN, 0, 0, 0, 0, "run_p0");
      cyc(0, 1, 0, 0, 0, S_RUN, 0, 0, 0, 0, "pause_req");
      for (int i = 0; i < 9; i++)
         cyc(0, 0, 0, 0, 0, S_PAUSE, 0, 0, 0, 0, "paused");
      cyc(0, 1, 0, 0, 0, S_PAUSE, 0, 0, 0, 0, "resume");
      cyc(0, 0, 0, 0, 0, S_RUN, 0, 0, 0, 0, "res_p2");

      // pause on the tick cycle: tick issued, prescaler back to 0
      cyc(0, 1, 0, 0, 0, S_RUN, 1, 0, 0, 0, "tick_pause");
      cyc(0, 0, 0, 0, 0, S_PAUSE, 0, 0, 0, 0, "hold0");
      cyc(0, 1, 0, 0, 0, S_PAUSE, 0, 0, 0, 0, "resume2");
      cyc(0, 0, 0, 0, 0, S_RUN, 0, 0, 0, 0, "r2_p0");
      cyc(0, 0, 0, 0, 0, S_RUN, 0, 0, 0, 0, "r2_p1");

      // overflow only on a tick with 59.999
      cyc(0, 0, 0, 0, 20'h59999, S_RUN, 0, 0, 0, 0, "no_ovf");
      cyc(0, 0, 0, 0, 20'h59999, S_RUN, 1, 0, 0, 0, "ovf_tick");
      cyc(0, 0, 0, 0, 0, S_RUN, 0, 0, 1, 0, "ovf_p0");
      cyc(0, 0, 0, 0, 0, S_RUN, 0, 0, 1, 0, "ovf_p1");
      cyc(0, 0, 0, 0, 0, S_RUN, 0, 0, 1, 0, "ovf_p2");

      // all three buttons on a tick cycle: clear wins, tick suppressed
      cyc(0, 1, 1, 1, 0, S_RUN, 0, 0, 1, 0, "clear_all");
      cyc(0, 1, 1, 1, 0, S_IDLE, 0, 1, 0, 0, "cleared");
      cyc(0, 0, 0, 0, 0, S_IDLE, 0, 0, 0, 0, "clr_done");

      // start held 20 cycles: one transition only
      cyc(0, 1, 0, 0, 0, S_IDLE, 0, 0, 0, 0, "hold_s0");
      for (int k = 1; k < 20; k++)
         cyc(0, 1, 0, 0, 0, S_RUN, (k % 4) == 0, 0, 0, 0, "hold_s");
      cyc(0, 0, 0, 0, 0, S_RUN, 1, 0, 0, 0, "release");

`ifdef STOPWATCH_LAP_EN
      cyc(0, 0, 1, 0, 20'h01234, S_RUN, 0, 0, 0, 0, "lap_req");
      cyc(0, 0, 0, 0, 20'h05678, S_LAP, 0, 0, 0, 20'h01234, "lap_hold");
      cyc(0, 0, 1, 0, 20'h05679, S_LAP, 0, 0, 0, 20'h01234, "lap_back");
      cyc(0, 0, 0, 0, 20'h05680, S_RUN, 1, 0, 0, 20'h01234, "lap_run");
`else
      cyc(0, 0, 1, 0, 20'h01234, S_RUN, 0, 0, 0, 0, "lap_ign1");
      cyc(0, 0, 0, 0, 20'h05678, S_RUN, 0, 0, 0, 0, "lap_ign2");
      cyc(0, 0, 1, 0, 20'h05679, S_RUN, 0, 0, 0, 0, "lap_ign3");
      cyc(0, 0, 0, 0, 20'h05680, S_RUN, 1, 0, 0, 0, "lap_ign4");
`endif
      cyc(0, 0, 0, 0, 0, S_RUN, 0, 0, 0, 0, "tail");

      for (int i = 0; i < 10 && q.size() > 0; i++)
         @(posedge clk);
      n_chk++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain left=%0d exp=0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
